sap_alu: RTL



---
 rtl/sap_alu_pkg.sv | 21 ++
 rtl/sap_mul_seq.sv | 57 +++++
 rtl/sap_alu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sap_alu_pkg.sv
// Shared types for the SAP ALU: operation codes and controller states.
package sap_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_ADC = 3'd2,
    OP_SBC = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/sap_mul_seq.sv
// Shift-add unsigned multiplier datapath. One partial product is accumulated
// per step; product_o already includes the contribution of the current step,
// so the controller can capture the final product on the last step edge.
module sap_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 count_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] prodNext;

  // Accumulate the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    prodNext = prod_q;
    if (mplier_q[0]) begin
      prodNext = prod_q + mcand_q;
    end
  end

  // Operand latch on load, then one shift/add and counter decrement per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      count_q  <= '0;
    end else if (load_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      prod_q   <= '0;
      count_q  <= CW'(WIDTH);
    end else if (step_i) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      prod_q   <= prodNext;
      count_q  <= count_q - CW'(1);
    end
  end

  // The counter reaches zero on this step edge, so prodNext is the final product.
  assign count_zero_o = (count_q == CW'(1));
  assign product_o    = prodNext;

endmodule

// File: rtl/sap_alu.sv
// Registered SAP ALU: single-cycle add/sub/logic path, sequential multiply,
// result and flag registers, and a tri-state driver onto the W bus.
module sap_alu
  import sap_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_data_in,
  input  logic [WIDTH-1:0] b_data_in,
  input  logic             Eu,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             busy,
  output logic             done
);

  alu_state_t         state_q, state_d;
  alu_op_t            opSel;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;
  logic               zero_q;

  logic [WIDTH-1:0]   bOperand;
  logic               carryIn;
  logic [WIDTH:0]     addSum;
  logic [WIDTH-1:0]   aluResult;
  logic               aluCarry;

  logic               mulLoad;
  logic               mulStep;
  logic               mulLast;
  logic [2*WIDTH-1:0] mulProduct;
  logic               writeAlu;
  logic               writeMul;

  assign opSel = alu_op_t'(op);

  sap_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (mulLoad),
    .step_i       (mulStep),
    .a_i          (a_data_in),
    .b_i          (b_data_in),
    .product_o    (mulProduct),
    .count_zero_o (mulLast)
  );

  // Single-cycle path: subtraction is A + ~B + carry-in, ADC/SBC reuse the stored carry.
  always_comb begin
    bOperand  = b_data_in;
    carryIn   = 1'b0;
    case (opSel)
      OP_SUB:  begin bOperand = ~b_data_in; carryIn = 1'b1;    end
      OP_ADC:  begin bOperand = b_data_in;  carryIn = carry_q; end
      OP_SBC:  begin bOperand = ~b_data_in; carryIn = carry_q; end
      default: begin bOperand = b_data_in;  carryIn = 1'b0;    end
    endcase
    addSum    = {1'b0, a_data_in} + {1'b0, bOperand} + {{WIDTH{1'b0}}, carryIn};
    aluResult = addSum[WIDTH-1:0];
    aluCarry  = addSum[WIDTH];
    case (opSel)
      OP_AND:  begin aluResult = a_data_in & b_data_in; aluCarry = 1'b0; end
      OP_OR:   begin aluResult = a_data_in | b_data_in; aluCarry = 1'b0; end
      OP_XOR:  begin aluResult = a_data_in ^ b_data_in; aluCarry = 1'b0; end
      OP_MUL:  begin aluResult = '0;                    aluCarry = 1'b0; end
      default: ;
    endcase
  end

  // Controller state register; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start is only honoured in IDLE, multiply runs until the counter empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (opSel == OP_MUL) ? MUL : DONE;
      MUL:     if (mulLast) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decoded controls: status outputs, multiplier load/step and result write strobes.
  always_comb begin
    busy     = (state_q == MUL);
    done     = (state_q == DONE);
    mulLoad  = (state_q == IDLE) && start && (opSel == OP_MUL);
    mulStep  = (state_q == MUL);
    writeAlu = (state_q == IDLE) && start && (opSel != OP_MUL);
    writeMul = (state_q == MUL) && mulLast;
  end

  // Result and flags only change when an operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else if (writeAlu) begin
      result_q <= aluResult;
      carry_q  <= aluCarry;
      zero_q   <= (aluResult == '0);
    end else if (writeMul) begin
      result_q <= mulProduct[WIDTH-1:0];
      carry_q  <= |mulProduct[2*WIDTH-1:WIDTH];
      zero_q   <= (mulProduct[WIDTH-1:0] == '0);
    end
  end

  assign data_out   = Eu ? result_q : 'z;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;

endmodule
